// File: rtl/mux_n_to_1_hold.sv
// ============================================================================
// mux_n_to_1_hold : registered N-to-1 selector that holds its output on idle
// cycles, with load index, hold counter and sticky conflict.  Rev 1.0
// ============================================================================
`default_nettype none

module mux_n_to_1_hold #(
  parameter int                WIDTH     = 8,
  parameter int                N         = 3,
  parameter int                STRICT    = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [N-1:0]         sel,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic [IW-1:0]        sel_idx,
  output logic                 conflict,
  output logic [7:0]           hold_cnt
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    sel_idx_q, sel_idx_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  logic             any_sel;
  logic             multi_sel;
  logic             load;
  logic [IW-1:0]    low_idx;
  logic [WIDTH-1:0] low_data;

  always_comb begin
    any_sel   = |sel;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_sel = (sel & (sel - 1'b1)) != '0;
    low_idx   = '0;
    low_data  = data_in[WIDTH-1:0];
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        low_idx  = IW'(i);
        low_data = data_in[i*WIDTH +: WIDTH];
      end
    end
    load = any_sel && !((STRICT != 0) && multi_sel);
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    sel_idx_d   = sel_idx_q;
    hold_cnt_d  = hold_cnt_q;
    conflict_d  = conflict_q;

    if (load) begin
      out_d       = low_data;
      out_valid_d = 1'b1;
      sel_idx_d   = low_idx;
      hold_cnt_d  = 8'd0;
    end else if (hold_cnt_q != 8'hFF) begin
      hold_cnt_d  = hold_cnt_q + 8'd1;
    end

    // A conflict in the same cycle as a clear keeps the flag set.
    if (multi_sel) begin
      conflict_d = 1'b1;
    end else if (clr_err) begin
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= RESET_VAL;
      out_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      conflict_q  <= 1'b0;
      hold_cnt_q  <= 8'd0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_idx_q   <= sel_idx_d;
      conflict_q  <= conflict_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel_idx   = sel_idx_q;
  assign conflict  = conflict_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

`default_nettype wire
